addr_seq: RTL and testbench



---
 rtl/addr_seq.sv | 129 ++++++++++++
 tb/tb_addr_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/addr_seq.sv
// Address sequencer: latches an inclusive window on start and steps the ROM address
// from start to finish, holding each address for TICK_DIV cycles, with loop and abort.
module addr_seq #(
  parameter int ADDR_W   = 8,
  parameter int TICK_DIV = 1000,
  parameter int DIV_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] addr_finish,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(TICK_DIV - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] lo_reg, lo_next;
  logic [ADDR_W-1:0] hi_reg, hi_next;
  logic [DIV_W-1:0]  cnt_reg, cnt_next;
  logic              valid_reg, valid_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              dwell_end;
  logic              at_finish;
  logic              window_ok;

  assign dwell_end = (cnt_reg == CNT_LAST);
  // End of window is detected by equality, so finish = all-ones never wraps.
  assign at_finish = (addr_reg == hi_reg);
  assign window_ok = (addr_start <= addr_finish);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      lo_reg    <= '0;
      hi_reg    <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      lo_reg    <= lo_next;
      hi_reg    <= hi_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start && !abort && window_ok) state_next = RUN;
      RUN: begin
        if (abort) state_next = IDLE;
        else if (dwell_end && at_finish && !loop_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_next  = addr_reg;
    lo_next    = lo_reg;
    hi_next    = hi_reg;
    cnt_next   = cnt_reg;
    valid_next = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        // abort dominates start; a reversed window only raises err
        if (start && !abort) begin
          if (window_ok) begin
            lo_next    = addr_start;
            hi_next    = addr_finish;
            addr_next  = addr_start;
            cnt_next   = '0;
            valid_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          addr_next = '0;
          cnt_next  = '0;
        end else if (dwell_end) begin
          cnt_next = '0;
          if (!at_finish) begin
            addr_next  = addr_reg + 1'b1;
            valid_next = 1'b1;
          end else if (loop_en) begin
            addr_next  = lo_reg;
            valid_next = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign addr_out   = addr_reg;
  assign addr_valid = valid_reg;
  assign busy       = (state_reg == RUN);
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_addr_seq.sv
// Directed bench for addr_seq with TICK_DIV=4: full windows, looping, bound changes,
// abort, reversed window, single-address window and mid-run reset.
module tb_addr_seq;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst, start, abort, loop_en;
  logic [7:0] addr_start, addr_finish;
  logic [7:0] addr_out;
  logic       addr_valid, busy, done, err;

  int n_cmp = 0;
  int n_err = 0;

  addr_seq #(.ADDR_W(8), .TICK_DIV(TD), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
    .addr_start(addr_start), .addr_finish(addr_finish),
    .addr_out(addr_out), .addr_valid(addr_valid), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int a, input int v, input int b,
                           input int d, input int e);
    check({tag, ".addr"},  int'(addr_out),   a);
    check({tag, ".valid"}, int'(addr_valid), v);
    check({tag, ".busy"},  int'(busy),       b);
    check({tag, ".done"},  int'(done),       d);
    check({tag, ".err"},   int'(err),        e);
  endtask

  // Runs a window for 'passes' passes (loop_en dropped during the last pass),
  // optionally changing input bounds at chg_t and pulsing start at start_t.
  task automatic run_seq(input string name, input logic [7:0] lo, input logic [7:0] hi,
                         input int passes, input int chg_t, input int start_t);
    int w, p, t_end, strobes;
    w = int'(hi) - int'(lo) + 1;
    p = w * TD;
    t_end = passes * p;
    strobes = 0;
    addr_start = lo; addr_finish = hi; loop_en = (passes > 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= t_end; t++) begin
      check_out($sformatf("%s.t%0d", name, t), int'(lo) + ((t - 1) % p) / TD,
                ((t - 1) % TD) == 0 ? 1 : 0, 1, 0, 0);
      if (addr_valid) strobes++;
      if (t == chg_t) begin addr_start = hi + 8'd1; addr_finish = hi + 8'd15; end
      if (t == start_t) start = 1'b1;
      if (passes > 1 && t == (passes - 1) * p + 1) loop_en = 1'b0;
      tick();
      start = 1'b0;
    end
    check_out({name, ".done"}, int'(hi), 0, 0, 1, 0);
    check({name, ".strobes"}, strobes, w * passes);
    tick();
    check_out({name, ".post"}, int'(hi), 0, 0, 0, 0);
    $display("window %0d..%0d x%0d: %0d cycles to done, %0d strobes", lo, hi, passes,
             t_end + 1, strobes);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    addr_start = 8'd0; addr_finish = 8'd0;
    tick(); tick();
    check_out("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    check_out("idle", 0, 0, 0, 0, 0);
    $display("reset: outputs idle");

    // window 1..15: addr 15 held t=57..60, done at t=61 (cycle 71 for start at 10)
    run_seq("w1_15", 8'd1, 8'd15, 1, 0, 0);

    // looping: two wraps back to 46, done only when the third pass ends
    run_seq("loop46_60", 8'd46, 8'd60, 3, 0, 0);

    // bounds switched mid-run plus start pulsed in the last cycle: ignored
    run_seq("chg16_30", 8'd16, 8'd30, 1, 20, 60);
    run_seq("w31_45", 8'd31, 8'd45, 1, 0, 0);

    // abort on the 3rd address (t=9..12 holds 18)
    addr_start = 8'd16; addr_finish = 8'd30; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < 9; t++) tick();
    check_out("abort.pre", 18, 1, 1, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_out("abort.post", 0, 0, 0, 0, 0);
    tick();
    check_out("abort.post2", 0, 0, 0, 0, 0);
    $display("abort at addr 18: idle next cycle");

    // start and abort together from IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_out("startabort", 0, 0, 0, 0, 0);
    tick();
    check_out("startabort2", 0, 0, 0, 0, 0);
    $display("start+abort in idle: ignored");

    // reversed window
    addr_start = 8'd20; addr_finish = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    check_out("err", 0, 0, 0, 0, 1);
    tick();
    check_out("err.post", 0, 0, 0, 0, 0);
    $display("window 20..10: err pulse");

    run_seq("w5_5", 8'd5, 8'd5, 1, 0, 0);

    // top of address space: equality end detection, no wrap
    run_seq("w253_255", 8'd253, 8'd255, 1, 0, 0);

    // reset mid-run, start during RUN
    addr_start = 8'd16; addr_finish = 8'd30; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < 7; t++) tick();
    check_out("rstmid.pre", 17, 0, 1, 0, 0);
    start = 1'b1; addr_start = 8'd40; addr_finish = 8'd50;
    tick();
    start = 1'b0;
    check_out("startrun", 17, 0, 1, 0, 0);
    tick();
    check_out("startrun2", 18, 1, 1, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("rstmid", 0, 0, 0, 0, 0);
    tick();
    check_out("rstmid.post", 0, 0, 0, 0, 0);
    $display("reset mid-run: silent stop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
